// File: rtl/wheel_size_entry.sv
// wheel_size_entry: wheel-circumference entry controller for the cycle computer
//
// The rider edits three BCD digits of the circumference (cm) with the Mode and
// Trip buttons while the mode controller holds ws_en high. Confirming a value
// inside [MIN_CM, MAX_CM] pulses ready and commits it to ws_circ. An out-of-range
// value reverts the working digits and restarts editing at the hundreds digit.
//
// Ports:
//   clock      system clock
//   Rst        asynchronous, active-high reset
//   ws_en      entry request level from the mode controller
//   nMode      Mode button, active low, asynchronous
//   nTrip      Trip button, active low, asynchronous
//   ws_digit1  hundreds digit shown (BCD, 15 = blank)
//   ws_digit2  tens digit shown
//   ws_digit3  units digit shown
//   ready      one-cycle pulse when an entry is committed
//   ws_circ    committed circumference in cm, binary
//
// Optional feature macro: WS_BLINK_EN (blinks the selected digit while editing).
module wheel_size_entry #(
    parameter int DEF_D1    = 2,
    parameter int DEF_D2    = 1,
    parameter int DEF_D3    = 3,
    parameter int MIN_CM    = 100,
    parameter int MAX_CM    = 299,
    parameter int BLINK_DIV = 512
) (
    input  logic       clock,
    input  logic       Rst,
    input  logic       ws_en,
    input  logic       nMode,
    input  logic       nTrip,
    output logic [3:0] ws_digit1,
    output logic [3:0] ws_digit2,
    output logic [3:0] ws_digit3,
    output logic       ready,
    output logic [9:0] ws_circ
);
    typedef enum logic [2:0] {IDLE, WAIT_REL, EDIT1, EDIT2, EDIT3, CHECK, DONE} state_t;

    state_t state, state_nx;
    logic [1:0] m_sync, t_sync;
    logic m_last, t_last, en_last;
    logic m_fall, t_fall, mode_ev, trip_ev, start, v_ok;
    logic [3:0] e1, e2, e3, c1, c2, c3;
    logic [9:0] v;
    logic [2:0] blank;

    function automatic logic [3:0] inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Two-flop synchronisers followed by a falling-edge detector; all released high.
    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            m_sync  <= 2'b11;
            t_sync  <= 2'b11;
            m_last  <= 1'b1;
            t_last  <= 1'b1;
            en_last <= 1'b0;
        end else begin
            m_sync  <= {m_sync[0], nMode};
            t_sync  <= {t_sync[0], nTrip};
            m_last  <= m_sync[1];
            t_last  <= t_sync[1];
            en_last <= ws_en;
        end
    end

    assign m_fall  = m_last & ~m_sync[1];
    assign t_fall  = t_last & ~t_sync[1];
    // Simultaneous presses cancel each other.
    assign mode_ev = m_fall & ~t_fall;
    assign trip_ev = t_fall & ~m_fall;
    // Only a fresh rising edge of ws_en starts a session, so a level still held
    // after a commit cannot re-enter.
    assign start   = ws_en & ~en_last;
    assign v       = 10'(e1) * 10'd100 + 10'(e2) * 10'd10 + 10'(e3);
    assign v_ok    = (v >= 10'(MIN_CM)) && (v <= 10'(MAX_CM));

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = WAIT_REL;
            WAIT_REL: if (m_sync[1] & t_sync[1]) state_nx = EDIT1;
            EDIT1:    if (mode_ev) state_nx = EDIT2;
            EDIT2:    if (mode_ev) state_nx = EDIT3;
            EDIT3:    if (mode_ev) state_nx = CHECK;
            CHECK:    state_nx = v_ok ? DONE : EDIT1;
            default:  state_nx = IDLE;
        endcase
        if (!ws_en && (state == WAIT_REL || state == EDIT1 || state == EDIT2 || state == EDIT3))
            state_nx = IDLE;
    end

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            e1      <= 4'(DEF_D1);
            e2      <= 4'(DEF_D2);
            e3      <= 4'(DEF_D3);
            c1      <= 4'(DEF_D1);
            c2      <= 4'(DEF_D2);
            c3      <= 4'(DEF_D3);
            ws_circ <= 10'(DEF_D1 * 100 + DEF_D2 * 10 + DEF_D3);
        end else begin
            if ((state == IDLE && start) || (state == CHECK && !v_ok)) begin
                e1 <= c1;
                e2 <= c2;
                e3 <= c3;
            end
            if (state == EDIT1 && trip_ev) e1 <= inc(e1);
            if (state == EDIT2 && trip_ev) e2 <= inc(e2);
            if (state == EDIT3 && trip_ev) e3 <= inc(e3);
            if (state == DONE) begin
                ws_circ <= v;
                c1      <= e1;
                c2      <= e2;
                c3      <= e3;
            end
        end
    end

`ifdef WS_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);
    logic [BW-1:0] bcnt;
    logic boff;

    // Any button edge restarts the blink at the visible phase so feedback is immediate.
    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            bcnt <= '0;
            boff <= 1'b0;
        end else if (m_fall | t_fall) begin
            bcnt <= '0;
            boff <= 1'b0;
        end else if (bcnt == BW'(BLINK_DIV - 1)) begin
            bcnt <= '0;
            boff <= ~boff;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    assign blank = {state == EDIT1, state == EDIT2, state == EDIT3} & {3{boff}};
`else
    assign blank = (BLINK_DIV > 0) ? 3'b000 : 3'b000;
`endif

    assign ws_digit1 = blank[2] ? 4'hF : (state == IDLE) ? c1 : e1;
    assign ws_digit2 = blank[1] ? 4'hF : (state == IDLE) ? c2 : e2;
    assign ws_digit3 = blank[0] ? 4'hF : (state == IDLE) ? c3 : e3;
    assign ready     = (state == DONE);
endmodule

// File: tb/tb_wheel_size_entry.sv
// tb_wheel_size_entry: directed table-driven bench for wheel_size_entry
module tb_wheel_size_entry;
    logic clock = 1'b0;
    logic Rst = 1'b1;
    logic ws_en = 1'b0;
    logic nMode = 1'b1;
    logic nTrip = 1'b1;
    logic [3:0] ws_digit1, ws_digit2, ws_digit3;
    logic ready;
    logic [9:0] ws_circ;
    int nvec = 0;
    int nmis = 0;
    int rdy_cnt = 0;

    typedef enum {OP_TRIP, OP_MODE, OP_BOTH, OP_EN0, OP_EN1} op_t;
    typedef struct {
        op_t op;
        logic [3:0] d1, d2, d3;
        logic [9:0] circ;
        int rdy;
    } vec_t;
    vec_t tv[$];

    wheel_size_entry #(.BLINK_DIV(4)) dut (
        .clock(clock), .Rst(Rst), .ws_en(ws_en), .nMode(nMode), .nTrip(nTrip),
        .ws_digit1(ws_digit1), .ws_digit2(ws_digit2), .ws_digit3(ws_digit3),
        .ready(ready), .ws_circ(ws_circ)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (ready === 1'b1) rdy_cnt <= rdy_cnt + 1;

    function automatic vec_t mk(op_t o, int a, int b, int c, int circ, int r);
        vec_t x;
        x.op = o; x.d1 = 4'(a); x.d2 = 4'(b); x.d3 = 4'(c); x.circ = 10'(circ); x.rdy = r;
        return x;
    endfunction

    task automatic chk(string nm, int a, int b, int c, int circ, int r);
        nvec++;
        if (ws_digit1 !== 4'(a) || ws_digit2 !== 4'(b) || ws_digit3 !== 4'(c) ||
            ws_circ !== 10'(circ) || rdy_cnt !== r || ready !== 1'b0) begin
            nmis++;
            $display("FAIL %s: got %0d/%0d/%0d circ=%0d readies=%0d ready=%b, want %0d/%0d/%0d circ=%0d readies=%0d ready=0",
                     nm, ws_digit1, ws_digit2, ws_digit3, ws_circ, rdy_cnt, ready, a, b, c, circ, r);
        end
    endtask

    task automatic cv(string nm, logic [3:0] got, int want);
        nvec++;
        if (got !== 4'(want)) begin
            nmis++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic press(logic m, logic t);
        @(negedge clock);
        nMode = m;
        nTrip = t;
        repeat (4) @(negedge clock);
        nMode = 1'b1;
        nTrip = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    task automatic set_en(logic e);
        @(negedge clock);
        ws_en = e;
        repeat (6) @(negedge clock);
    endtask

    task automatic blink_run(string nm, int val);
        @(negedge clock);
        nTrip = 1'b0;
        repeat (3) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            cv($sformatf("%s_%0d", nm, i), ws_digit2, (i < 4) ? val : 15);
        end
        nTrip = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        // Rejected 513 session, then accepted 257 session, then wrap/both/idle/abort.
        tv.push_back(mk(OP_TRIP, 3, 1, 3, 213, 0));
        tv.push_back(mk(OP_TRIP, 4, 1, 3, 213, 0));
        tv.push_back(mk(OP_TRIP, 5, 1, 3, 213, 0));
        tv.push_back(mk(OP_MODE, 5, 1, 3, 213, 0));
        tv.push_back(mk(OP_MODE, 5, 1, 3, 213, 0));
        tv.push_back(mk(OP_MODE, 2, 1, 3, 213, 0));
        tv.push_back(mk(OP_MODE, 2, 1, 3, 213, 0));
        for (int k = 2; k <= 5; k++) tv.push_back(mk(OP_TRIP, 2, k, 3, 213, 0));
        tv.push_back(mk(OP_MODE, 2, 5, 3, 213, 0));
        for (int k = 4; k <= 7; k++) tv.push_back(mk(OP_TRIP, 2, 5, k, 213, 0));
        tv.push_back(mk(OP_MODE, 2, 5, 7, 257, 1));
        tv.push_back(mk(OP_TRIP, 2, 5, 7, 257, 1));
        tv.push_back(mk(OP_EN0, 2, 5, 7, 257, 1));
        tv.push_back(mk(OP_EN1, 2, 5, 7, 257, 1));
        tv.push_back(mk(OP_MODE, 2, 5, 7, 257, 1));
        for (int k = 1; k <= 10; k++) tv.push_back(mk(OP_TRIP, 2, (5 + k) % 10, 7, 257, 1));
        tv.push_back(mk(OP_BOTH, 2, 5, 7, 257, 1));
        tv.push_back(mk(OP_TRIP, 2, 6, 7, 257, 1));
        tv.push_back(mk(OP_MODE, 2, 6, 7, 257, 1));
        tv.push_back(mk(OP_TRIP, 2, 6, 8, 257, 1));
        tv.push_back(mk(OP_TRIP, 2, 6, 9, 257, 1));
        tv.push_back(mk(OP_EN0, 2, 5, 7, 257, 1));
        tv.push_back(mk(OP_EN1, 2, 5, 7, 257, 1));
        tv.push_back(mk(OP_MODE, 2, 5, 7, 257, 1));
        tv.push_back(mk(OP_TRIP, 2, 6, 7, 257, 1));

        repeat (3) @(negedge clock);
        Rst = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset", 2, 1, 3, 213, 0);

        ws_en = 1'b1;
        nMode = 1'b0;
        nTrip = 1'b0;
        repeat (20) @(negedge clock);
        chk("gesture_held", 2, 1, 3, 213, 0);
        nMode = 1'b1;
        nTrip = 1'b1;
        repeat (6) @(negedge clock);

        foreach (tv[i]) begin
            case (tv[i].op)
                OP_TRIP: press(1'b1, 1'b0);
                OP_MODE: press(1'b0, 1'b1);
                OP_BOTH: press(1'b0, 1'b0);
                OP_EN0:  set_en(1'b0);
                default: set_en(1'b1);
            endcase
            chk($sformatf("vec%0d", i), tv[i].d1, tv[i].d2, tv[i].d3, tv[i].circ, tv[i].rdy);
        end

        @(negedge clock);
        #3 Rst = 1'b1;
        ws_en = 1'b0;
        #1 chk("async_reset", 2, 1, 3, 213, 1);
        @(negedge clock);
        Rst = 1'b0;
        repeat (2) @(negedge clock);
        chk("after_reset", 2, 1, 3, 213, 1);

        set_en(1'b1);
        nTrip = 1'b0;
        @(posedge clock) #1 cv("latency_edge1", ws_digit1, 2);
        @(posedge clock) #1 cv("latency_edge2", ws_digit1, 2);
        @(posedge clock) #1 cv("latency_edge3", ws_digit1, 3);
        nTrip = 1'b1;
        repeat (4) @(negedge clock);

`ifdef WS_BLINK_EN
        press(1'b0, 1'b1);
        blink_run("blink_first", 2);
        blink_run("blink_restart", 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
